muldiv_unit: RTL and testbench

- Iterative multiply/divide unit for the execute stage.
- Owns the architectural HI/LO registers.
- Sits directly upstream of the writeback result select: its hi/lo outputs are the HI and LO data inputs of the mux4v that chooses among ALU result, memory data, HI and LO.
- Radix-2, one bit per cycle. The pipeline stalls on busy.

---
 rtl/muldiv_unit.sv | 196 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply/divide unit owning the architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, then a sign-fix cycle.
module muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              flush,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [2:0] OP_MULT = 3'd0;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_DIVU = 3'd3;
    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    // Unsigned view of |x|; MIN maps onto 2^(DATA_W-1), which fits unsigned.
    function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] x,
                                                    input logic is_signed);
        if (is_signed && x[DATA_W-1]) begin
            return -x;
        end
        return x;
    endfunction

    function automatic logic [DATA_W-1:0] neg_w(input logic signed [DATA_W-1:0] x,
                                                input logic neg);
        return neg ? -x : x;
    endfunction

    function automatic logic [2*DATA_W-1:0] neg_2w(input logic signed [2*DATA_W-1:0] x,
                                                   input logic neg);
        return neg ? -x : x;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  hi_q, hi_d;
    logic [DATA_W-1:0]  lo_q, lo_d;
    logic               done_q, done_d;

    logic [DATA_W-1:0]  acc_hi_q, acc_hi_d;
    logic [DATA_W-1:0]  acc_lo_q, acc_lo_d;
    logic [DATA_W-1:0]  opnd_q, opnd_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               dvz_q, dvz_d;

    logic               signed_op;
    logic [DATA_W-1:0]  mag_a, mag_b;
    logic [DATA_W:0]    mul_sum;
    logic [DATA_W:0]    div_shift;
    logic               div_ge;
    logic [DATA_W-1:0]  div_rem;
    logic [2*DATA_W-1:0] prod_fix;

    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        mag_a     = magnitude(a, signed_op);
        mag_b     = magnitude(b, signed_op);

        // acc_lo holds the multiplier (mult) or the dividend being shifted out (div)
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(DATA_W+1){1'b0}});
        div_shift = {acc_hi_q, acc_lo_q[DATA_W-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_rem   = div_ge ? DATA_W'(div_shift - {1'b0, opnd_q}) : div_shift[DATA_W-1:0];
        prod_fix  = neg_2w({acc_hi_q, acc_lo_q}, neg_q);

        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        a_d      = a_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dvz_d    = dvz_q;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    if (op <= OP_DIVU) begin
                        state_d  = S_RUN;
                        cnt_d    = CNT_W'(DATA_W - 1);
                        is_div_d = op[1];
                        neg_d    = signed_op && (a[DATA_W-1] ^ b[DATA_W-1]);
                        rneg_d   = signed_op && a[DATA_W-1];
                        dvz_d    = (b == '0);
                        a_d      = a;
                        acc_hi_d = '0;
                        acc_lo_d = op[1] ? mag_a : mag_b;
                        opnd_d   = op[1] ? mag_b : mag_a;
                    end else if (op == OP_MTHI) begin
                        hi_d = a;
                    end else if (op == OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            S_RUN: begin
                if (is_div_q) begin
                    acc_hi_d = div_rem;
                    acc_lo_d = {acc_lo_q[DATA_W-2:0], div_ge};
                end else begin
                    acc_hi_d = mul_sum[DATA_W:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[DATA_W-1:1]};
                end
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_FIX: begin
                // Divide by zero leaves HI as the raw dividend, whatever its sign.
                if (is_div_q && dvz_q) begin
                    hi_d = a_q;
                    lo_d = '1;
                end else if (is_div_q) begin
                    hi_d = neg_w(acc_hi_q, rneg_q);
                    lo_d = neg_w(acc_lo_q, neg_q);
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_hi_q <= acc_hi_d;
        acc_lo_q <= acc_lo_d;
        opnd_q   <= opnd_d;
        a_q      <= a_d;
        is_div_q <= is_div_d;
        neg_q    <= neg_d;
        rneg_q   <= rneg_d;
        dvz_q    <= dvz_d;
    end

    // Busy spans the last DATA_W-1 iterations plus the fix cycle.
    assign busy = (state_q == S_FIX) ||
                  ((state_q == S_RUN) && (cnt_q != CNT_W'(DATA_W - 1)));
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: transaction-level HI/LO model checked every
// cycle, plus hand-computed literal results for each test-plan case.
`timescale 1ns/100ps
module tb_muldiv_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start, flush;
    logic [2:0]    op;
    logic [W-1:0]  a, b;
    logic [W-1:0]  hi, lo;
    logic          busy, done;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]  m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int            m_rem = 0;
    bit            m_done = 1'b0;

    muldiv_unit #(.DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Architectural result of one mul/div operation, straight from the arithmetic rules.
    task automatic model_calc(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                              output logic [W-1:0] rh, output logic [W-1:0] rl);
        longint sx, sy, q, r;
        logic [63:0] pu;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        rh = '0;
        rl = '0;
        case (o)
            3'd0: begin q = sx * sy; rh = q[63:32]; rl = q[31:0]; end
            3'd1: begin pu = 64'(x) * 64'(y); rh = pu[63:32]; rl = pu[31:0]; end
            3'd2: begin
                if (y == 0) begin rh = x; rl = '1; end
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin rh = 0; rl = x; end
                else begin q = sx / sy; r = sx % sy; rl = q[31:0]; rh = r[31:0]; end
            end
            3'd3: begin
                if (y == 0) begin rh = x; rl = '1; end
                else begin rl = x / y; rh = x % y; end
            end
            default: ;
        endcase
    endtask

    // m_rem counts edges until the result lands; W+1 right after acceptance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi = '0; m_lo = '0; m_rem = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (flush) begin
                m_rem = 0;
            end else if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
                end
            end else if (start) begin
                if (op <= 3'd3) begin
                    model_calc(op, a, b, p_hi, p_lo);
                    m_rem = W + 1;
                end else if (op == 3'd4) m_hi = a;
                else if (op == 3'd5) m_lo = a;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_hi", hi, m_hi);
            chk("cyc_lo", lo, m_lo);
            chk("cyc_busy", busy, (m_rem >= 1 && m_rem <= W));
            chk("cyc_done", done, m_done);
        end
    end

    task automatic lit(input string nm, input logic [W-1:0] eh, input logic [W-1:0] el);
        chk({nm, "_hi"}, hi, eh);
        chk({nm, "_lo"}, lo, el);
        chk({nm, "_model_hi"}, m_hi, eh);
        chk({nm, "_model_lo"}, m_lo, el);
    endtask

    task automatic mv(input logic [2:0] o, input logic [W-1:0] v, input bit fl);
        @(negedge clk);
        #1 start = 1'b1; op = o; a = v; flush = fl;
        @(posedge clk);
        #2 start = 1'b0; flush = 1'b0; op = 3'd7;
    endtask

    task automatic run(input string nm, input logic [2:0] o, input logic [W-1:0] ra,
                       input logic [W-1:0] rb, input bit chain, input int inj_at,
                       input logic [2:0] iop, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input int flush_at, input bit exp_done);
        int n, bcnt;
        bit got;
        if (!chain) @(negedge clk);
        #1 start = 1'b1; op = o; a = ra; b = rb;
        @(posedge clk);
        #2 start = 1'b0; op = 3'd7;
        n = 0; bcnt = 0; got = 1'b0;
        while (n < 45 && !got) begin
            @(negedge clk);
            n++;
            if (busy) bcnt++;
            if (done) got = 1'b1;
            else if (n == inj_at || n == flush_at) begin
                #1;
                if (n == inj_at) begin start = 1'b1; op = iop; a = ia; b = ib; end
                if (n == flush_at) flush = 1'b1;
                @(posedge clk);
                #2 start = 1'b0; flush = 1'b0; op = 3'd7;
            end
        end
        if (exp_done) begin
            chk({nm, "_done_seen"}, got, 1);
            chk({nm, "_latency"}, n, W + 2);
            chk({nm, "_busy_cycles"}, bcnt, W);
        end else begin
            chk({nm, "_no_done"}, got, 0);
        end
    endtask

    initial begin
        start = 1'b0; flush = 1'b0; op = 3'd7; a = '0; b = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);

        mv(3'd4, 32'h1234_5678, 1'b0);
        mv(3'd5, 32'h9ABC_DEF0, 1'b0);
        @(negedge clk);
        lit("mthi_mtlo", 32'h1234_5678, 32'h9ABC_DEF0);

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("areset_hi", hi, 0);
        chk("areset_lo", lo, 0);
        #1 rst_n = 1'b1;

        run("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 0, 0, 3'd7, 0, 0, 0, 1);
        lit("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 3'd7, 0, 0, 0, 1);
        lit("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
        run("mult_min", 3'd0, 32'h8000_0000, 32'h8000_0000, 0, 0, 3'd7, 0, 0, 0, 1);
        lit("mult_min", 32'h4000_0000, 32'h0000_0000);
        run("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, 3'd7, 0, 0, 0, 1);
        lit("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run("divu", 3'd3, 32'd7, 32'd2, 0, 0, 3'd7, 0, 0, 0, 1);
        lit("divu", 32'd1, 32'd3);
        run("div_negb", 3'd2, 32'd100, 32'hFFFF_FFF9, 0, 0, 3'd7, 0, 0, 0, 1);
        lit("div_negb", 32'd2, 32'hFFFF_FFF2);
        run("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 3'd7, 0, 0, 0, 1);
        lit("div_ovf", 32'h0000_0000, 32'h8000_0000);
        run("divu_z", 3'd3, 32'd7, 32'd0, 0, 0, 3'd7, 0, 0, 0, 1);
        lit("divu_z", 32'h0000_0007, 32'hFFFF_FFFF);
        run("div_z", 3'd2, 32'hFFFF_FFF9, 32'd0, 0, 0, 3'd7, 0, 0, 0, 1);
        lit("div_z", 32'hFFFF_FFF9, 32'hFFFF_FFFF);

        run("mult_inj", 3'd0, 32'd3, 32'd4, 0, 10, 3'd3, 32'd100, 32'd7, 0, 1);
        lit("mult_inj", 32'd0, 32'd12);
        run("b2b_divu", 3'd3, 32'd100, 32'd7, 1, 0, 3'd7, 0, 0, 0, 1);
        lit("b2b_divu", 32'd2, 32'd14);

        mv(3'd4, 32'hAAAA_0000, 1'b0);
        mv(3'd5, 32'h0000_5555, 1'b0);
        run("flush_mid", 3'd1, 32'd6, 32'd7, 0, 0, 3'd7, 0, 0, 20, 0);
        lit("flush_mid", 32'hAAAA_0000, 32'h0000_5555);
        mv(3'd5, 32'd1, 1'b1);
        @(negedge clk);
        lit("flush_mtlo", 32'hAAAA_0000, 32'h0000_5555);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
